// File: rtl/axis_agent_pkg.sv
// Shared AXI-Stream agent definitions: bus width bundle and FIFO entry sizing.
package axis_agent_pkg;

  typedef struct packed {
    int unsigned DATA_W;
    int unsigned ID_W;
    int unsigned DEST_W;
    int unsigned USER_W;
  } bus_widths_t;

  localparam bus_widths_t AXIS_DEFAULT_WIDTHS = '{DATA_W: 16, ID_W: 8, DEST_W: 4, USER_W: 2};

  // Bits needed to hold one complete beat: data, strobe, keep, last, id, dest, user.
  function automatic int entry_width(input int data_w, input int id_w,
                                     input int dest_w, input int user_w);
    return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage for the stream FIFO: one synchronous write port, one asynchronous read port.
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with first-word fall-through output,
// occupancy and stored-packet counters.
module axis_sync_fifo
  import axis_agent_pkg::*;
#(
  parameter int DATA_W = int'(AXIS_DEFAULT_WIDTHS.DATA_W),
  parameter int ID_W   = int'(AXIS_DEFAULT_WIDTHS.ID_W),
  parameter int DEST_W = int'(AXIS_DEFAULT_WIDTHS.DEST_W),
  parameter int USER_W = int'(AXIS_DEFAULT_WIDTHS.USER_W),
  parameter int DEPTH  = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DATA_W-1:0]          s_tdata,
  input  logic [DATA_W/8-1:0]        s_tstrb,
  input  logic [DATA_W/8-1:0]        s_tkeep,
  input  logic                       s_tlast,
  input  logic [ID_W-1:0]            s_tid,
  input  logic [DEST_W-1:0]          s_tdest,
  input  logic [USER_W-1:0]          s_tuser,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATA_W-1:0]          m_tdata,
  output logic [DATA_W/8-1:0]        m_tstrb,
  output logic [DATA_W/8-1:0]        m_tkeep,
  output logic                       m_tlast,
  output logic [ID_W-1:0]            m_tid,
  output logic [DEST_W-1:0]          m_tdest,
  output logic [USER_W-1:0]          m_tuser,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = entry_width(DATA_W, ID_W, DEST_W, USER_W);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] lvl;
  logic [LVL_W-1:0] pkts;
  logic             run;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;
  logic [ENT_W-1:0] head;

  // run holds s_tready low through reset and for the edge that releases it.
  assign s_tready = run && (lvl != LVL_FULL);
  assign m_tvalid = (lvl != '0);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  assign wr_entry = {s_tuser, s_tdest, s_tid, s_tlast, s_tkeep, s_tstrb, s_tdata};

  axis_fifo_ram #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Stale storage must never leak out, so the head is forced to zero when empty.
  assign head = m_tvalid ? rd_entry : '0;
  assign {m_tuser, m_tdest, m_tid, m_tlast, m_tkeep, m_tstrb, m_tdata} = head;

  assign level     = lvl;
  assign pkt_count = pkts;

  // Pointer, occupancy and packet bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      run    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      pkts   <= '0;
    end else begin
      run <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   lvl <= lvl + LVL_ONE;
        2'b01:   lvl <= lvl - LVL_ONE;
        default: lvl <= lvl;
      endcase
      case ({push && s_tlast, pop && m_tlast})
        2'b10:   pkts <= pkts + LVL_ONE;
        2'b01:   pkts <= pkts - LVL_ONE;
        default: pkts <= pkts;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Bench for axis_sync_fifo: directed scenarios plus a random phase, all
// compared against a queue-based model of the stream FIFO.
module tb_axis_sync_fifo;

  localparam int DATA_W = 16;
  localparam int ID_W   = 8;
  localparam int DEST_W = 4;
  localparam int USER_W = 2;
  localparam int DEPTH  = 8;
  localparam int SW     = DATA_W / 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic [SW-1:0]     s_tstrb;
  logic [SW-1:0]     s_tkeep;
  logic              s_tlast;
  logic [ID_W-1:0]   s_tid;
  logic [DEST_W-1:0] s_tdest;
  logic [USER_W-1:0] s_tuser;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [SW-1:0]     m_tstrb;
  logic [SW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [ID_W-1:0]   m_tid;
  logic [DEST_W-1:0] m_tdest;
  logic [USER_W-1:0] m_tuser;
  logic [LW-1:0]     level;
  logic [LW-1:0]     pkt_count;

  axis_sync_fifo #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .DEST_W (DEST_W),
    .USER_W (USER_W),
    .DEPTH  (DEPTH)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tstrb   (s_tstrb),
    .s_tkeep   (s_tkeep),
    .s_tlast   (s_tlast),
    .s_tid     (s_tid),
    .s_tdest   (s_tdest),
    .s_tuser   (s_tuser),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tstrb   (m_tstrb),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tid     (m_tid),
    .m_tdest   (m_tdest),
    .m_tuser   (m_tuser),
    .level     (level),
    .pkt_count (pkt_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [SW-1:0]     strb;
    logic [SW-1:0]     keep;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  beat_t q[$];
  bit    run = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  task automatic check_outputs();
    beat_t h;
    h = '{default: '0};
    if (q.size() != 0) h = q[0];
    chk("s_tready",  32'(s_tready),  32'(run && (q.size() != DEPTH)));
    chk("m_tvalid",  32'(m_tvalid),  32'(q.size() != 0));
    chk("level",     32'(level),     32'(q.size()));
    chk("pkt_count", 32'(pkt_count), 32'(model_pkts()));
    chk("m_tdata",   32'(m_tdata),   32'(h.data));
    chk("m_tstrb",   32'(m_tstrb),   32'(h.strb));
    chk("m_tkeep",   32'(m_tkeep),   32'(h.keep));
    chk("m_tlast",   32'(m_tlast),   32'(h.last));
    chk("m_tid",     32'(m_tid),     32'(h.id));
    chk("m_tdest",   32'(m_tdest),   32'(h.dest));
    chk("m_tuser",   32'(m_tuser),   32'(h.user));
  endtask

  // One clock: decide what the edge should do from the model, let it happen, then compare.
  task automatic cycle();
    bit    do_push;
    bit    do_pop;
    beat_t b;
    do_push = s_tvalid && run && (q.size() < DEPTH);
    do_pop  = m_tready && (q.size() > 0);
    b = '{data: s_tdata, strb: s_tstrb, keep: s_tkeep, last: s_tlast,
          id: s_tid, dest: s_tdest, user: s_tuser};
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      q.delete();
      run = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(b);
      run = 1'b1;
    end
    check_outputs();
  endtask

  task automatic drive_beat(input logic [DATA_W-1:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = SW'($urandom);
    s_tkeep  = SW'($urandom);
    s_tlast  = last;
    s_tid    = ID_W'($urandom);
    s_tdest  = DEST_W'($urandom);
    s_tuser  = USER_W'($urandom);
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tid    = '0;
    s_tdest  = '0;
    s_tuser  = '0;
    m_tready = 1'b0;

    // Reset, then idle.
    cycle();
    cycle();
    aresetn = 1'b1;
    cycle();
    cycle();
    chk("idle_tready", 32'(s_tready), 32'd1);
    chk("idle_tdata",  32'(m_tdata),  32'd0);

    // Fill to full with 0x0001..0x0008, then try a 9th push.
    for (int i = 1; i <= DEPTH; i++) begin
      drive_beat(DATA_W'(i), 1'b0);
      cycle();
    end
    chk("full_level",  32'(level),    32'(DEPTH));
    chk("full_tready", 32'(s_tready), 32'd0);
    drive_beat(DATA_W'(16'h0009), 1'b0);
    cycle();
    chk("ovf_level", 32'(level), 32'(DEPTH));
    s_tvalid = 1'b0;

    // Drain in order.
    m_tready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain_data", 32'(m_tdata), 32'(i));
      cycle();
    end
    chk("drain_level", 32'(level), 32'd0);
    cycle();

    // Hold occupancy at 3 with concurrent push and pop.
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(DATA_W'($urandom), 1'($urandom));
      cycle();
    end
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_beat(DATA_W'($urandom), 1'($urandom));
      cycle();
      chk("steady_level", 32'(level), 32'd3);
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Two 3-beat packets, then pop one packet.
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_beat(DATA_W'($urandom), (i == 2) || (i == 5));
      cycle();
    end
    s_tvalid = 1'b0;
    chk("pkts_two", 32'(pkt_count), 32'd2);
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("pkts_one", 32'(pkt_count), 32'd1);
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-operation with five beats stored.
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_beat(DATA_W'($urandom), 1'($urandom));
      cycle();
    end
    s_tvalid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd5);
    aresetn = 1'b0;
    cycle();
    chk("rst_level",  32'(level),     32'd0);
    chk("rst_valid",  32'(m_tvalid),  32'd0);
    chk("rst_pkts",   32'(pkt_count), 32'd0);
    chk("rst_tready", 32'(s_tready),  32'd0);
    aresetn = 1'b1;
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_beat(DATA_W'($urandom), 1'($urandom_range(0, 3) == 0));
      else s_tvalid = 1'b0;
      m_tready = ($urandom_range(0, 2) != 0);
      if (i >= 150 && i < 200) m_tready = 1'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 16, tdata width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ID_W, default 8, tid width.
REQ-003 Parameter DEST_W, default 4, tdest width.
REQ-004 Parameter USER_W, default 2, tuser width.
REQ-005 Parameter DEPTH, default 8, entry count; SHALL be a power of two, at least 2.
REQ-006 Port list, in this order:
- aclk  in  1  single clock.
- aresetn  in  1  reset; synchronous, active-low.
- s_tvalid  in  1  upstream valid.
- s_tready  out  1  upstream ready.
- s_tdata  in  DATA_W  payload.
- s_tstrb  in  DATA_W/8  byte strobe.
- s_tkeep  in  DATA_W/8  byte keep.
- s_tlast  in  1  packet end.
- s_tid  in  ID_W  stream id.
- s_tdest  in  DEST_W  routing.
- s_tuser  in  USER_W  sideband.
- m_tvalid, m_tready, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser: the same widths with directions mirrored.
- level  out  $clog2(DEPTH)+1  current occupancy.
- pkt_count  out  $clog2(DEPTH)+1  number of stored entries with tlast=1.

Function
REQ-007 Push SHALL occur on an aclk edge where s_tvalid && s_tready; pop SHALL occur on an edge where m_tvalid && m_tready.
REQ-008 s_tready SHALL equal (level != DEPTH) while aresetn is high; it SHALL NOT depend on m_tready (no pass-through when full).
REQ-009 m_tvalid SHALL equal (level != 0); first-word fall-through.
REQ-010 Latency: a beat pushed at edge N SHALL appear on m_* with m_tvalid high after edge N, when the FIFO was empty; there is no combinational bypass.
REQ-011 All m_* payload signals SHALL present the oldest entry, held stable while m_tvalid && !m_tready.
REQ-012 m_* payload SHALL be all-zero whenever m_tvalid is low.
REQ-013 Beats SHALL exit in push order, and every field of a beat SHALL be preserved bit-exact.
REQ-014 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-015 Occupancy update per edge:
- push without pop: level increments.
- pop without push: level decrements.
- simultaneous push and pop (only possible when 0 < level < DEPTH): level unchanged.
REQ-016 pkt_count update per edge:
- increments on a push with s_tlast=1.
- decrements on a pop with m_tlast=1.
- both events on the same edge: pkt_count unchanged.
REQ-017 level SHALL never exceed DEPTH or wrap below 0.
REQ-018 A pop attempted when empty, or a push attempted when full, SHALL be ignored.
REQ-019 No state machine is required; behaviour SHALL be fully determined by the pointers and level.

Reset
REQ-020 While aresetn is low at an edge, the following SHALL be cleared: both pointers, level, pkt_count and m_tvalid; s_tready SHALL be 0.
REQ-021 s_tready SHALL rise at the first edge after aresetn returns high.
REQ-022 Reset asserted mid-operation SHALL discard all stored beats; m_tvalid SHALL be 0 after that edge.
REQ-023 Storage array contents need no reset.

Structure
REQ-024 Width parameters SHALL be settable from the shared axis_agent_pkg::bus_widths_t struct fields DATA_W, ID_W, DEST_W, USER_W; no new typedefs are required.
REQ-025 Storage SHALL be a sub-module axis_fifo_ram:
- one write port and one asynchronous read port.
- width = DATA_W + 2*(DATA_W/8) + 1 + ID_W + DEST_W + USER_W.
- depth = DEPTH.
REQ-026 Packing order of the concatenated entry (MSB to LSB) SHALL be: tuser, tdest, tid, tlast, tkeep, tstrb, tdata.

Verification
REQ-027 Reset then idle -> s_tready=1, m_tvalid=0, level=0, m_tdata=0.
REQ-028 Push 8 beats with tdata 0x0001..0x0008, m_tready=0 -> s_tready=0 after the 8th, level=8; a 9th push is ignored.
REQ-029 Drain the full FIFO with m_tready=1 -> data 0x0001..0x0008 in order with tid/tdest/tuser intact; level ends at 0.
REQ-030 Continuous push and pop with level held at 3 for 20 cycles (pointers wrap) -> level stays 3; no loss or duplication.
REQ-031 Two packets of 3 beats (tlast on the 3rd) -> pkt_count=2; after 3 pops pkt_count=1.
REQ-032 aresetn low for one cycle with level=5 -> level=0, m_tvalid=0, pkt_count=0 on the next cycle.
